// File: rtl/multi_blink_pkg.sv
// Shared encodings for the multi-channel LED blink controller.
// Holds the mode and channel-state enums plus the toggle-count width helper.
package multi_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_HOLD  = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLINK = 2'b01,
    ST_BURST = 2'b10
  } state_t;

  // Holds 0..2*burst_n; the final toggle is never stored, it ends the burst.
  function automatic int tcnt_width(input int burst_n);
    return $clog2(2 * burst_n + 1);
  endfunction

endpackage

// File: rtl/blink_chan.sv
// One LED channel: off / on / blink-while-held / fixed-length burst, stepped by the shared tick.
// LED registered, 1 cycle from sw/mode; no backpressure, inputs are sampled every cycle.
module blink_chan
  import multi_blink_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en,
  input  logic             sw,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  output logic             led,
  output logic             busy
);

  localparam int TC_W = tcnt_width(BURST_N);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(2 * BURST_N - 1);

  state_t           state, state_nxt;
  logic             led_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TC_W-1:0]  tcnt, tcnt_nxt;
  logic             sw_prev;
  logic             step;
  mode_t            mode_e;

  assign mode_e = mode_t'(mode);
  assign step   = tick & en;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      led     <= 1'b0;
      cnt     <= '0;
      tcnt    <= '0;
      sw_prev <= sw;
    end else begin
      state   <= state_nxt;
      led     <= led_nxt;
      cnt     <= cnt_nxt;
      tcnt    <= tcnt_nxt;
      sw_prev <= sw;
    end
  end

  always_comb begin
    state_nxt = state;
    led_nxt   = led;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    case (state)
      ST_IDLE: begin
        led_nxt  = (mode_e == MODE_ON);
        cnt_nxt  = '0;
        tcnt_nxt = '0;
        if (mode_e == MODE_HOLD && sw) begin
          state_nxt = ST_BLINK;
          led_nxt   = 1'b1;
          cnt_nxt   = period;
        end else if (mode_e == MODE_BURST && sw && !sw_prev) begin
          state_nxt = ST_BURST;
          led_nxt   = 1'b1;
          cnt_nxt   = period;
        end
      end
      ST_BLINK: begin
        // Release or mode change beats a coincident toggle.
        if (mode_e != MODE_HOLD || !sw) begin
          state_nxt = ST_IDLE;
          led_nxt   = (mode_e == MODE_ON);
          cnt_nxt   = '0;
          tcnt_nxt  = '0;
        end else if (step) begin
          if (cnt == '0) begin
            led_nxt = ~led;
            cnt_nxt = period;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end
      ST_BURST: begin
        if (mode_e != MODE_BURST) begin
          state_nxt = ST_IDLE;
          led_nxt   = (mode_e == MODE_ON);
          cnt_nxt   = '0;
          tcnt_nxt  = '0;
        end else if (step) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
          end else if (tcnt == TC_LAST) begin
            state_nxt = ST_IDLE;
            led_nxt   = 1'b0;
            cnt_nxt   = '0;
            tcnt_nxt  = '0;
          end else begin
            led_nxt  = ~led;
            cnt_nxt  = period;
            tcnt_nxt = tcnt + TC_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        led_nxt   = 1'b0;
        cnt_nxt   = '0;
        tcnt_nxt  = '0;
      end
    endcase
  end

endmodule

// File: rtl/multi_blink_ctrl.sv
// Multi-channel LED controller: shared prescaler tick feeding CHANNELS independent blink_chan instances.
// LEDs registered, 1 cycle from sw_i/mode_i; no backpressure, en_i low freezes all timing.
module multi_blink_ctrl
  import multi_blink_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 8,
  parameter int PRESC_DIV = 50000,
  parameter int BURST_N   = 3
) (
  input  logic                      sysclk,
  input  logic                      reset_n,
  input  logic                      en_i,
  input  logic [CHANNELS-1:0]       sw_i,
  input  logic [2*CHANNELS-1:0]     mode_i,
  input  logic [CNT_W*CHANNELS-1:0] period_i,
  output logic [CHANNELS-1:0]       led_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic                      tick_o
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      presc  <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= en_i && (presc == PRESC_MAX);
      if (en_i) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    blink_chan #(
      .CNT_W   (CNT_W),
      .BURST_N (BURST_N)
    ) u_chan (
      .clk    (sysclk),
      .rst_n  (reset_n),
      .tick   (tick_o),
      .en     (en_i),
      .sw     (sw_i[c]),
      .mode   (mode_i[2*c +: 2]),
      .period (period_i[c*CNT_W +: CNT_W]),
      .led    (led_o[c]),
      .busy   (busy_o[c])
    );
  end

endmodule

// File: doc/multi_blink_ctrl.md
Name: multi_blink_ctrl

Overview:
Parametrised, multi-channel successor to the single-switch LED toggle/countdown logic.
Each channel drives one LED in one of four modes: off, steady on, blink-while-held, or a fixed-length burst on the switch's rising edge.
Blink timing comes from a shared prescaler tick plus a per-channel reloadable down-counter.
Sits after the sync_meta synchronisers in the board top level and drives the LED pins directly.

Parameters:
CHANNELS, 4, number of independent switch/LED channels
CNT_W, 8, width of per-channel half-period value and down-counter
PRESC_DIV, 50000, sysclk cycles per prescaler tick (>=2)
BURST_N, 3, full on/off cycles emitted per burst (>=1)

Ports:
sysclk  in  1  system clock (PLL output)
reset_n  in  1  reset, synchronous to sysclk, active-low
en_i  in  1  global enable; low freezes prescaler and all channel timers
sw_i  in  CHANNELS  per-channel switch, already synchronised upstream
mode_i  in  2*CHANNELS  per-channel mode: 00 OFF, 01 ON, 10 HOLD, 11 BURST
period_i  in  CNT_W*CHANNELS  per-channel half-period; one half-period = period+1 ticks
led_o  out  CHANNELS  registered LED drive
busy_o  out  CHANNELS  1 while the channel is in BLINK or BURST
tick_o  out  1  registered one-cycle prescaler tick, for observability

Behaviour:
- Reset (sampled on the sysclk edge, reset_n=0): led_o=0, busy_o=0, tick_o=0, prescaler=0, all states IDLE, counters=0, toggle counts=0.
- During reset, each channel's sw_prev register loads sw_i, so a switch held high through reset never produces a rising edge.
- Prescaler counts 0..PRESC_DIV-1 while en_i=1, then wraps to 0.
  - tick_o is asserted for one cycle, in the cycle after the count equals PRESC_DIV-1.
  - Channels act on the registered tick.
- en_i=0: prescaler holds its value, tick_o=0, timers and LEDs hold. Mode changes and OFF/ON still apply.
- Channel FSM states: IDLE, BLINK, BURST.
  - IDLE: led = (mode==ON). Leave IDLE on either:
    - mode HOLD with sw_i=1 -> BLINK
    - mode BURST with rising edge (sw_i=1, sw_prev=0) -> BURST
  - On entry to BLINK or BURST, in the same clock edge: led<=1, counter<=period value, toggle count<=0. The period is sampled here; later changes to period_i take effect at the next reload only.
  - Each tick in BLINK/BURST: if counter==0 then toggle led and reload period, else decrement counter.
- BLINK: sw_i=0 -> IDLE with led<=0 on the next edge. This wins over a simultaneous tick/toggle.
- BURST:
  - Toggle count increments on each toggle.
  - When the toggle that would make the count 2*BURST_N occurs, go to IDLE with led<=0.
  - Rising edges during BURST are ignored (no retrigger).
- Mode change while busy: the next edge goes to IDLE and clears counters. The LED takes the new mode's IDLE value.
- period=0 toggles on every tick. period = 2^CNT_W - 1 gives 2^CNT_W ticks per half-period, with no overflow.
- Toggle count width is $clog2(2*BURST_N+1).
- Per-channel arithmetic is unsigned; there is no cross-channel interaction except the shared tick.
- Latency from sw_i/mode_i change to led_o: 1 cycle.

Decomposition:
- Package multi_blink_pkg: mode encodings (MODE_OFF/ON/HOLD/BURST), FSM state typedef/encodings, and a helper function for toggle-count width.
- Sub-module blink_chan: one channel's FSM, down-counter, toggle count and sw_prev. It takes tick, en, sw, mode and period, and returns led and busy.
- Top level: prescaler, tick register, and a generate loop of CHANNELS blink_chan instances.

Test Plan (PRESC_DIV=4, CNT_W=8, BURST_N=3):
1. reset_n low for 3 cycles with sw_i=all 1 and mode=BURST -> led_o=0, busy_o=0, tick_o=0; after release, no burst starts.
2. mode_i ch0 set 01, then 00 -> led_o[0] becomes 1 one cycle later, then 0 one cycle after the change back; busy_o[0] stays 0.
3. ch1 HOLD, period=2, sw_i[1] rises:
   - led_o[1]=1 next cycle, then toggles every 3 ticks (12 cycles).
   - sw_i[1] falls coincident with a tick -> led_o[1]=0 and busy_o[1]=0 next cycle.
4. ch2 BURST, period=0, rising edge:
   - Exactly 6 toggles with led high for 3 periods, then led=0 and busy=0.
   - A second rising edge mid-burst is ignored.
5. en_i=0 mid-blink for 20 cycles -> tick_o=0 and led_o/counter frozen; after en_i=1 the blink resumes with the remaining count.
6. reset_n pulsed low for 1 cycle mid-burst on all channels -> all outputs 0 after that edge; no spurious restart.
